// File: rtl/apb_arbiter_rr_pick.sv
// Combinational round-robin select: the first requester at or after rr_ptr,
// wrapping modulo N, returned as a one-hot vector.
module apb_arbiter_rr_pick #(
  parameter int N     = 2,
  parameter int W_IDX = 1
) (
  input  logic [N-1:0]     req,
  input  logic [W_IDX-1:0] rr_ptr,
  output logic [N-1:0]     gnt
);
  int   idx;
  logic found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(rr_ptr) + k) % N;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/onehot_mux.sv
// One-hot select multiplexer: ORs together the slices whose select bit is set.
// An all-zero select gives an all-zero output.
module onehot_mux #(
  parameter int N = 2,
  parameter int W = 8
) (
  input  logic [N-1:0]   sel,
  input  logic [N*W-1:0] din,
  output logic [W-1:0]   dout
);
  always_comb begin
    dout = '0;
    for (int i = 0; i < N; i++)
      if (sel[i]) dout |= din[i*W +: W];
  end
endmodule

// File: rtl/apb_arbiter.sv
// Round-robin APB arbiter: N upstream masters share one downstream APB port.
// Each granted transfer is replayed downstream as SETUP then ACCESS.
module apb_arbiter #(
  parameter int N_MASTERS = 2,
  parameter int W_ADDR    = 16,
  parameter int W_DATA    = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_MASTERS*W_ADDR-1:0]   apbs_paddr,
  input  logic [N_MASTERS-1:0]          apbs_psel,
  input  logic [N_MASTERS-1:0]          apbs_penable,
  input  logic [N_MASTERS-1:0]          apbs_pwrite,
  input  logic [N_MASTERS*W_DATA-1:0]   apbs_pwdata,
  output logic [N_MASTERS-1:0]          apbs_pready,
  output logic [N_MASTERS*W_DATA-1:0]   apbs_prdata,
  output logic [N_MASTERS-1:0]          apbs_pslverr,
  output logic [W_ADDR-1:0]             apbm_paddr,
  output logic                          apbm_psel,
  output logic                          apbm_penable,
  output logic                          apbm_pwrite,
  output logic [W_DATA-1:0]             apbm_pwdata,
  input  logic                          apbm_pready,
  input  logic [W_DATA-1:0]             apbm_prdata,
  input  logic                          apbm_pslverr
);
  localparam int W_IDX = $clog2(N_MASTERS);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t               state, state_nxt;
  logic [N_MASTERS-1:0] grant, grant_nxt, pick;
  logic [W_IDX-1:0]     rr_ptr, rr_ptr_nxt, win_idx;
  logic                 done;

  // Upstream penable carries no sequencing information here.
  logic unused_penable;
  assign unused_penable = ^apbs_penable;

  apb_arbiter_rr_pick #(.N(N_MASTERS), .W_IDX(W_IDX)) u_pick (
    .req    (apbs_psel),
    .rr_ptr (rr_ptr),
    .gnt    (pick)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < N_MASTERS; i++)
      if (grant[i]) win_idx = W_IDX'(i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      grant  <= grant_nxt;
      rr_ptr <= rr_ptr_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant;
    rr_ptr_nxt = rr_ptr;
    case (state)
      IDLE:
        if (|apbs_psel) begin
          grant_nxt = pick;
          state_nxt = SETUP;
        end
      SETUP:  state_nxt = ACCESS;
      ACCESS:
        // Completes even if the granted master dropped psel, so the bus never hangs.
        if (apbm_pready) begin
          state_nxt  = IDLE;
          grant_nxt  = '0;
          rr_ptr_nxt = (win_idx == W_IDX'(N_MASTERS - 1)) ? '0 : win_idx + 1'b1;
        end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  assign apbm_psel    = (state != IDLE);
  assign apbm_penable = (state == ACCESS);
  assign done         = (state == ACCESS) && apbm_pready;

  onehot_mux #(.N(N_MASTERS), .W(W_ADDR)) u_mux_addr (
    .sel (grant), .din (apbs_paddr), .dout (apbm_paddr)
  );
  onehot_mux #(.N(N_MASTERS), .W(W_DATA)) u_mux_wdata (
    .sel (grant), .din (apbs_pwdata), .dout (apbm_pwdata)
  );
  onehot_mux #(.N(N_MASTERS), .W(1)) u_mux_write (
    .sel (grant), .din (apbs_pwrite), .dout (apbm_pwrite)
  );

  assign apbs_pready  = grant & {N_MASTERS{done}};
  assign apbs_pslverr = grant & {N_MASTERS{(state == ACCESS) && apbm_pslverr}};
  assign apbs_prdata  = {N_MASTERS{apbm_prdata}};
endmodule

// File: tb/tb_apb_arbiter.sv
// Bench for apb_arbiter: transaction-level reference model compared every cycle,
// directed scenarios with literal expectations, a random phase, and a 3-master instance.
module tb_apb_arbiter;
  localparam int N = 2, WA = 16, WD = 32;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [WA-1:0]   addr  [N];
  logic [WD-1:0]   wdata [N];
  logic [N-1:0]    psel, pen, pwr;
  logic [N*WA-1:0] s_paddr;
  logic [N*WD-1:0] s_pwdata;
  logic [N-1:0]    s_pready, s_pslverr;
  logic [N*WD-1:0] s_prdata;
  logic [WA-1:0]   m_paddr;
  logic            m_psel, m_pen, m_pwrite;
  logic [WD-1:0]   m_pwdata;
  logic            m_pready, m_pslverr;
  logic [WD-1:0]   m_prdata;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign s_paddr[g*WA +: WA]  = addr[g];
    assign s_pwdata[g*WD +: WD] = wdata[g];
  end

  apb_arbiter #(.N_MASTERS(N), .W_ADDR(WA), .W_DATA(WD)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .apbs_paddr(s_paddr), .apbs_psel(psel), .apbs_penable(pen), .apbs_pwrite(pwr),
    .apbs_pwdata(s_pwdata), .apbs_pready(s_pready), .apbs_prdata(s_prdata),
    .apbs_pslverr(s_pslverr),
    .apbm_paddr(m_paddr), .apbm_psel(m_psel), .apbm_penable(m_pen), .apbm_pwrite(m_pwrite),
    .apbm_pwdata(m_pwdata), .apbm_pready(m_pready), .apbm_prdata(m_prdata),
    .apbm_pslverr(m_pslverr)
  );

  // Three-master instance for the pointer-wrap scenario.
  logic [2:0]      p3_psel;
  logic [3*WA-1:0] p3_addr;
  logic [2:0]      d3_pready;
  logic [WA-1:0]   d3_paddr;
  logic [3*WD-1:0] unused_d3_prdata;
  logic [2:0]      unused_d3_pslverr;
  logic            unused_d3_psel, unused_d3_pen, unused_d3_pwrite;
  logic [WD-1:0]   unused_d3_pwdata;
  assign p3_addr = {16'h0300, 16'h0200, 16'h0100};

  apb_arbiter #(.N_MASTERS(3), .W_ADDR(WA), .W_DATA(WD)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .apbs_paddr(p3_addr), .apbs_psel(p3_psel), .apbs_penable(p3_psel), .apbs_pwrite(3'b000),
    .apbs_pwdata('0), .apbs_pready(d3_pready), .apbs_prdata(unused_d3_prdata),
    .apbs_pslverr(unused_d3_pslverr),
    .apbm_paddr(d3_paddr), .apbm_psel(unused_d3_psel), .apbm_penable(unused_d3_pen),
    .apbm_pwrite(unused_d3_pwrite), .apbm_pwdata(unused_d3_pwdata), .apbm_pready(1'b1),
    .apbm_prdata('0), .apbm_pslverr(1'b0)
  );

  int checks = 0, fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: owner of the bus (-1 = none), cycles since grant, next-priority index.
  int own = -1, age = 0, ptr = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      own = -1; age = 0; ptr = 0;
    end else if (own < 0) begin
      for (int k = 0; k < N; k++)
        if (own < 0 && psel[(ptr + k) % N]) begin
          own = (ptr + k) % N;
          age = 1;
        end
    end else if (age == 1) begin
      age = 2;
    end else if (m_pready) begin
      ptr = (own + 1) % N;
      own = -1;
    end
  end

  logic [WA-1:0] setup_log [$];

  always @(negedge clk) begin
    logic [N-1:0]  e_rdy, e_err;
    logic [WA-1:0] e_addr;
    logic [WD-1:0] e_wd;
    logic          e_wr;
    e_rdy = '0; e_err = '0; e_addr = '0; e_wd = '0; e_wr = 1'b0;
    if (own >= 0) begin
      e_addr = addr[own];
      e_wd   = wdata[own];
      e_wr   = pwr[own];
      if (age >= 2) begin
        e_rdy[own] = m_pready;
        e_err[own] = m_pslverr;
      end
    end
    chk("psel",    m_psel,    own >= 0);
    chk("penable", m_pen,     own >= 0 && age >= 2);
    chk("paddr",   m_paddr,   e_addr);
    chk("pwrite",  m_pwrite,  e_wr);
    chk("pwdata",  m_pwdata,  e_wd);
    chk("pready",  s_pready,  e_rdy);
    chk("pslverr", s_pslverr, e_err);
    for (int i = 0; i < N; i++) chk("prdata", s_prdata[i*WD +: WD], m_prdata);
    if (m_psel && !m_pen) setup_log.push_back(m_paddr);
  end

  logic [N-1:0] seen_rdy = '0;
  always @(negedge clk) seen_rdy <= s_pready;

  initial begin
    psel = '0; pen = '0; pwr = '0; p3_psel = '0;
    for (int i = 0; i < N; i++) begin addr[i] = '0; wdata[i] = '0; end
    m_pready = 1'b1; m_pslverr = 1'b0; m_prdata = '0;

    repeat (2) @(negedge clk);
    chk("rst_psel", m_psel, 0);
    chk("rst_penable", m_pen, 0);
    chk("rst_pready", s_pready, 0);
    chk("rst_pslverr", s_pslverr, 0);
    tick(); rst_n = 1'b1;

    // Both masters keep requesting: grants alternate 0,1,0,1.
    tick();
    setup_log.delete();
    addr[0] = 16'h0100; addr[1] = 16'h0200;
    psel = 2'b11; pen = 2'b11;
    repeat (12) tick();
    psel = '0; pen = '0;
    chk("rr_count", setup_log.size(), 4);
    for (int k = 0; k < 4 && k < setup_log.size(); k++)
      chk("rr_order", setup_log[k], (k % 2 == 0) ? 16'h0100 : 16'h0200);

    // Single zero-wait write from master 0.
    tick();
    addr[0] = 16'h4010; wdata[0] = 32'hDEADBEEF; pwr[0] = 1'b1; psel[0] = 1'b1;
    @(negedge clk); chk("t1_c0_psel", m_psel, 0);
    tick(); pen[0] = 1'b1;
    @(negedge clk);
    chk("t1_c1_psel", m_psel, 1); chk("t1_c1_pen", m_pen, 0);
    chk("t1_c1_addr", m_paddr, 16'h4010); chk("t1_c1_wr", m_pwrite, 1);
    tick();
    @(negedge clk);
    chk("t1_c2_pen", m_pen, 1); chk("t1_c2_wdata", m_pwdata, 32'hDEADBEEF);
    chk("t1_c2_pready", s_pready, 2'b01);
    tick(); psel[0] = 1'b0; pen[0] = 1'b0; pwr[0] = 1'b0;

    // Master 1 read with 3 slave wait states.
    addr[1] = 16'h0A00; pwr[1] = 1'b0; psel[1] = 1'b1; m_pready = 1'b0;
    tick(); pen[1] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      @(negedge clk);
      chk("t3_wait_pen", m_pen, 1); chk("t3_wait_pready", s_pready, 0);
    end
    tick(); m_pready = 1'b1; m_prdata = 32'h12345678;
    @(negedge clk);
    chk("t3_pready", s_pready, 2'b10);
    chk("t3_prdata", s_prdata[WD +: WD], 32'h12345678);
    tick(); psel[1] = 1'b0; pen[1] = 1'b0;

    // Slave error on master 0.
    addr[0] = 16'h0044; pwr[0] = 1'b1; psel[0] = 1'b1; m_pslverr = 1'b1;
    tick(); tick();
    @(negedge clk);
    chk("t4_pready", s_pready, 2'b01); chk("t4_pslverr", s_pslverr, 2'b01);
    tick(); psel[0] = 1'b0; m_pslverr = 1'b0;

    // Reset asserted during ACCESS, master 1 pending.
    addr[0] = 16'h0055; psel[0] = 1'b1; m_pready = 1'b0;
    tick(); tick();
    addr[1] = 16'h0066; psel[1] = 1'b1;
    tick(); rst_n = 1'b0; #1;
    chk("t5_rst_psel", m_psel, 0); chk("t5_rst_pen", m_pen, 0);
    chk("t5_rst_pready", s_pready, 0);
    psel[0] = 1'b0; m_pready = 1'b1;
    tick(); rst_n = 1'b1;
    @(negedge clk); chk("t5_idle", m_psel, 0);
    tick(); @(negedge clk);
    chk("t5_setup", m_psel, 1); chk("t5_addr", m_paddr, 16'h0066);
    tick(); @(negedge clk); chk("t5_pready", s_pready, 2'b10);
    tick(); psel[1] = 1'b0;

    // Three masters: serve 1 (ptr->2), then {0,1} wraps to 0 (ptr->1), then 1 wins.
    p3_psel = 3'b010;
    tick(); tick(); @(negedge clk); chk("n3_first", d3_pready, 3'b010);
    tick(); p3_psel = 3'b011;
    tick(); @(negedge clk); chk("n3_wrap_addr", d3_paddr, 16'h0100);
    tick(); @(negedge clk); chk("n3_wrap_rdy", d3_pready, 3'b001);
    tick();
    tick(); @(negedge clk); chk("n3_next_addr", d3_paddr, 16'h0200);
    tick(); @(negedge clk); chk("n3_next_rdy", d3_pready, 3'b010);
    tick(); p3_psel = '0;

    // Random traffic against the model.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (psel[i]) begin
          if (seen_rdy[i] || $urandom_range(0, 99) == 0) begin
            psel[i] = 1'b0; pen[i] = 1'b0;
          end else pen[i] = 1'b1;
        end else if ($urandom_range(0, 2) == 0) begin
          psel[i]  = 1'b1; pen[i] = 1'b0;
          addr[i]  = WA'($urandom);
          wdata[i] = $urandom;
          pwr[i]   = 1'($urandom_range(0, 1));
        end
      end
      m_pready  = ($urandom_range(0, 3) != 0);
      m_pslverr = ($urandom_range(0, 7) == 0);
      m_prdata  = $urandom;
    end
    psel = '0; pen = '0; m_pready = 1'b1;
    repeat (8) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/apb_arbiter.md
Name: apb_arbiter

Overview:
- Shares one APB bus between N_MASTERS upstream APB requesters, e.g. the CPU debug port and the DMA engine, using round-robin arbitration.
- Its downstream port feeds the peripheral APB address splitter.
- Each transfer is arbitrated, replayed downstream as a clean SETUP/ACCESS sequence, and completed back to the winning master only.
- Losing masters are stalled with pready low until they are served.

Parameters:
N_MASTERS, 2, number of upstream APB masters (≥2)
W_ADDR, 16, address width
W_DATA, 32, data width

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
apbs_paddr  input  N_MASTERS*W_ADDR  per-master address
apbs_psel  input  N_MASTERS  per-master select (request)
apbs_penable  input  N_MASTERS  per-master enable
apbs_pwrite  input  N_MASTERS  per-master write flag
apbs_pwdata  input  N_MASTERS*W_DATA  per-master write data
apbs_pready  output  N_MASTERS  per-master ready
apbs_prdata  output  N_MASTERS*W_DATA  read data, downstream prdata replicated
apbs_pslverr  output  N_MASTERS  per-master error
apbm_paddr  output  W_ADDR  downstream address
apbm_psel  output  1  downstream select
apbm_penable  output  1  downstream enable
apbm_pwrite  output  1  downstream write flag
apbm_pwdata  output  W_DATA  downstream write data
apbm_pready  input  1  downstream ready
apbm_prdata  input  W_DATA  downstream read data
apbm_pslverr  input  1  downstream error

Behaviour:
- Clocking and reset:
  - Single clock domain, clk.
  - rst_n is asynchronous and active-low.
  - Reset values: state=IDLE, grant=0 (one-hot, no master), rr_ptr=0.
  - Consequently at reset: apbm_psel=0, apbm_penable=0, all apbs_pready=0, all apbs_pslverr=0.
- Upstream protocol:
  - A master requests by asserting psel.
  - It must hold paddr/pwrite/pwdata stable, and hold psel high, until it sees pready&penable.
  - Its penable timing is ignored for sequencing.
- State machine (IDLE, SETUP, ACCESS):
  - IDLE:
    - If any apbs_psel is high, pick a winner: the first requesting index at or after rr_ptr, wrapping modulo N_MASTERS.
    - Register the winner as a one-hot grant and move to SETUP.
    - With no request, stay in IDLE with grant=0.
  - SETUP: apbm_psel=1, apbm_penable=0. Move unconditionally to ACCESS.
  - ACCESS:
    - apbm_psel=1, apbm_penable=1.
    - On apbm_pready=1: go to IDLE, set rr_ptr=(winner+1) mod N_MASTERS, clear grant.
    - Otherwise stay in ACCESS; downstream wait states are unbounded.
- Downstream muxing:
  - apbm_paddr, apbm_pwrite and apbm_pwdata are one-hot muxed from the registered grant.
  - This is combinational from upstream inputs, which are stable by protocol.
  - With grant=0 these outputs are 0.
- Upstream responses:
  - apbs_pready[i] = (state==ACCESS) & grant[i] & apbm_pready.
  - apbs_pslverr[i] = (state==ACCESS) & grant[i] & apbm_pslverr.
  - apbs_prdata is apbm_prdata replicated to all masters; it is only meaningful with pready.
- Latency:
  - Request seen in IDLE at cycle 0, SETUP at cycle 1, ACCESS at cycle 2.
  - A zero-wait slave completes at cycle 2, i.e. 3 cycles minimum per transfer.
  - One IDLE cycle always separates consecutive transfers.
- Boundary conditions:
  - Simultaneous requests: round-robin order. A master that just completed has lowest priority next time.
  - The completing master may re-request in the following IDLE cycle; this is treated as a new transfer.
  - Protocol violation, granted master drops psel mid-transfer: the downstream transfer still completes and the FSM returns to IDLE. Never hang.
  - rr_ptr wrap: from N_MASTERS-1 back to 0.
  - Reset mid-transfer: downstream psel/penable drop immediately (asynchronous); no pready is issued.

Decomposition:
- State encodings and W_IDX (clog2 of N_MASTERS) are localparams inside the module; no shared package is needed.
- Reuse the existing onehot_mux for the paddr, pwdata and pwrite muxes.
- One natural sub-module: apb_arbiter_rr_pick, the combinational round-robin priority select (inputs: req vector and rr_ptr; output: one-hot winner).

Test Plan:
- Single request, master 0 writes addr 0x4010, data 0xDEADBEEF, zero-wait slave -> downstream sees SETUP at cycle 1 and ACCESS at cycle 2 with those values; apbs_pready[0] pulses in cycle 2; apbs_pready[1] stays 0.
- Both masters request at the same cycle after reset -> master 0 is served first, then master 1. With both continuously re-requesting, grants alternate 0,1,0,1.
- Slave inserts 3 wait states on a read from master 1 returning 0x12345678 -> FSM holds ACCESS for 4 cycles; apbs_pready[1] asserts only in the last cycle, with apbs_prdata = 0x12345678.
- Slave returns pslverr=1 on the final ACCESS cycle -> the granted master sees pslverr=1 and pready=1; the other master sees neither.
- rst_n asserted during ACCESS -> apbm_psel and apbm_penable are 0 immediately. After release, the FSM is in IDLE with rr_ptr=0 and a pending master 1 request is granted normally.
- N_MASTERS=3 with rr_ptr=2 and requests from masters 0 and 1 -> master 0 wins (wrap), and rr_ptr becomes 1.
